multicycle_control_unit: RTL and testbench

- Sequencing controller for the multicycle RV32I core; it replaces the single-cycle combinational decoder.
- Steps each instruction through fetch, decode, execute, memory and writeback, using ready handshakes to instruction and data memory.
- Reuses the single-cycle control encodings and gates every write enable by state.
- Adds three behaviours: SRAI/SRLI distinction, illegal-instruction and memory-timeout traps, and an optional retired-instruction counter.

---
 rtl/multicycle_control_unit_if.sv | 39 +++
 rtl/multicycle_control_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Control-unit bundle: instruction-register fields, memory handshakes and datapath controls.
// The control unit drives through the master modport; the datapath or a bench uses slave.
interface multicycle_control_unit_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       OpCode;
  logic [2:0]       Funct3;
  logic [6:0]       Funct7;
  logic             IMemReady;
  logic             DMemReady;
  logic             IMemReq;
  logic             DMemReq;
  logic             IRWr;
  logic             PCWr;
  logic             RUWr;
  logic [1:0]       RUDataWrSrc;
  logic             ALUASrc;
  logic             ALUBSrc;
  logic [3:0]       ALUOp;
  logic             DMWr;
  logic [2:0]       DMCtrl;
  logic [2:0]       ImmSrc;
  logic [4:0]       BrOp;
  logic             Trap;
  logic [2:0]       State;
  logic [CNT_W-1:0] InstRet;

  modport master (
    input  OpCode, Funct3, Funct7, IMemReady, DMemReady,
    output IMemReq, DMemReq, IRWr, PCWr, RUWr, RUDataWrSrc, ALUASrc, ALUBSrc,
           ALUOp, DMWr, DMCtrl, ImmSrc, BrOp, Trap, State, InstRet
  );

  modport slave (
    output OpCode, Funct3, Funct7, IMemReady, DMemReady,
    input  IMemReq, DMemReq, IRWr, PCWr, RUWr, RUDataWrSrc, ALUASrc, ALUBSrc,
           ALUOp, DMWr, DMCtrl, ImmSrc, BrOp, Trap, State, InstRet
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with illegal-op and timeout traps.
// Define CTRL_PERF_CNT_EN to build the retired-instruction counter behind InstRet.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input logic                     clk,
  input logic                     rst,
  multicycle_control_unit_if.master bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;

  logic [3:0] decAluOp;
  logic       decAluASrc, decAluBSrc;
  logic [1:0] decRuSrc;
  logic [2:0] decDmCtrl, decImmSrc;
  logic [4:0] decBrOp;
  logic       isLoad, isStore, isBranch, illegal;

  logic imemReq, irWr, dmemReq, dmWr, ruWr, pcWr, decActive;
  logic ready, timedOut;

  always_comb begin
    decAluOp   = 4'b0000;
    decAluASrc = 1'b0;
    decAluBSrc = 1'b0;
    decRuSrc   = 2'b00;
    decDmCtrl  = 3'b000;
    decImmSrc  = 3'b000;
    decBrOp    = 5'b00000;
    isLoad     = 1'b0;
    isStore    = 1'b0;
    isBranch   = 1'b0;
    illegal    = 1'b0;
    case (bus.OpCode)
      OP_R: begin
        decAluOp = {bus.Funct7[5], bus.Funct3};
        if (bus.Funct7 == 7'h20)
          illegal = !((bus.Funct3 == 3'b000) || (bus.Funct3 == 3'b101));
        else
          illegal = (bus.Funct7 != 7'h00);
      end
      OP_IARITH: begin
        decAluBSrc = 1'b1;
        // Only the right shift carries an arithmetic/logical choice in Funct7.
        if (bus.Funct3 == 3'b101) begin
          decAluOp = {bus.Funct7[5], 3'b101};
          illegal  = !((bus.Funct7 == 7'h00) || (bus.Funct7 == 7'h20));
        end else begin
          decAluOp = {1'b0, bus.Funct3};
          illegal  = (bus.Funct3 == 3'b001) && (bus.Funct7 != 7'h00);
        end
      end
      OP_LOAD: begin
        isLoad     = 1'b1;
        decAluBSrc = 1'b1;
        decRuSrc   = 2'b01;
        decDmCtrl  = bus.Funct3;
        illegal    = (bus.Funct3 == 3'b011) || (bus.Funct3[2:1] == 2'b11);
      end
      OP_STORE: begin
        isStore    = 1'b1;
        decAluBSrc = 1'b1;
        decDmCtrl  = bus.Funct3;
        decImmSrc  = 3'b001;
        illegal    = (bus.Funct3 > 3'b010);
      end
      OP_BRANCH: begin
        isBranch  = 1'b1;
        decImmSrc = 3'b101;
        decBrOp   = {2'b01, bus.Funct3};
        illegal   = (bus.Funct3[2:1] == 2'b01);
      end
      OP_JAL: begin
        decImmSrc = 3'b110;
        decBrOp   = 5'b10000;
        decRuSrc  = 2'b10;
      end
      OP_JALR: begin
        decAluBSrc = 1'b1;
        decBrOp    = 5'b10000;
        decRuSrc   = 2'b10;
        illegal    = (bus.Funct3 != 3'b000);
      end
      OP_LUI: begin
        decImmSrc = 3'b010;
        decRuSrc  = 2'b11;
      end
      OP_AUIPC: begin
        decAluASrc = 1'b1;
        decAluBSrc = 1'b1;
        decImmSrc  = 3'b010;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign ready    = (state_q == S_FETCH) ? bus.IMemReady : bus.DMemReady;
  assign timedOut = TIMEOUT_EN && (waitCnt_q == WAIT_LIMIT);

  always_comb begin
    state_d = state_q;
    imemReq = 1'b0;
    irWr    = 1'b0;
    dmemReq = 1'b0;
    dmWr    = 1'b0;
    ruWr    = 1'b0;
    pcWr    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imemReq = 1'b1;
        if (bus.IMemReady) begin
          irWr    = 1'b1;
          state_d = S_DECODE;
        end else if (timedOut) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: state_d = illegal ? S_TRAP : S_EXECUTE;
      S_EXECUTE: begin
        if (isLoad || isStore) begin
          state_d = S_MEM;
        end else if (isBranch) begin
          pcWr    = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEM: begin
        dmemReq = 1'b1;
        dmWr    = isStore;
        if (bus.DMemReady) begin
          pcWr    = isStore;
          state_d = isStore ? S_FETCH : S_WRITEBACK;
        end else if (timedOut) begin
          state_d = S_TRAP;
        end
      end
      S_WRITEBACK: begin
        ruWr    = 1'b1;
        pcWr    = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    // Any state change restarts the wait count, so each FETCH/MEM visit starts from zero.
    waitCnt_d = waitCnt_q;
    if (state_d != state_q)
      waitCnt_d = '0;
    else if (((state_q == S_FETCH) || (state_q == S_MEM)) && !ready)
      waitCnt_d = waitCnt_q + WAIT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  assign decActive = (state_q == S_DECODE) || (state_q == S_EXECUTE) ||
                     (state_q == S_MEM)    || (state_q == S_WRITEBACK);

  assign bus.IMemReq     = imemReq & ~rst;
  assign bus.IRWr        = irWr & ~rst;
  assign bus.DMemReq     = dmemReq & ~rst;
  assign bus.DMWr        = dmWr & ~rst;
  assign bus.RUWr        = ruWr & ~rst;
  assign bus.PCWr        = pcWr & ~rst;
  assign bus.Trap        = (state_q == S_TRAP) & ~rst;
  assign bus.State       = rst ? 3'd0 : state_q;
  assign bus.ALUOp       = (decActive && !rst) ? decAluOp   : 4'b0000;
  assign bus.ALUASrc     = (decActive && !rst) ? decAluASrc : 1'b0;
  assign bus.ALUBSrc     = (decActive && !rst) ? decAluBSrc : 1'b0;
  assign bus.RUDataWrSrc = (decActive && !rst) ? decRuSrc   : 2'b00;
  assign bus.DMCtrl      = (decActive && !rst) ? decDmCtrl  : 3'b000;
  assign bus.ImmSrc      = (decActive && !rst) ? decImmSrc  : 3'b000;
  assign bus.BrOp        = ((state_q == S_EXECUTE) && !rst) ? decBrOp : 5'b00000;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] instRet_q, instRet_d;

  assign instRet_d = pcWr ? (instRet_q + CNT_W'(1)) : instRet_q;

  always_ff @(posedge clk) begin
    if (rst)
      instRet_q <= '0;
    else
      instRet_q <= instRet_d;
  end

  assign bus.InstRet = rst ? {CNT_W{1'b0}} : instRet_q;
`else
  assign bus.InstRet = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: an instruction-level model predicts every cycle's outputs,
// and a few hand-computed literals pin latencies, encodings, trap timing and counter wrap.
module tb_multicycle_control_unit;

  localparam int TB_TIMEOUT = 15;
  localparam int TB_CNT_W   = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [2:0] st;
    logic       imemReq, irWr, dmemReq, dmWr, ruWr;
    logic [1:0] ruSrc;
    logic       aluA, aluB;
    logic [3:0] aluOp;
    logic [2:0] dmCtrl, immSrc;
    logic [4:0] brOp;
    logic       pcWr, trap;
  } expT;

  logic clk = 1'b0;
  logic rst = 1'b1;

  multicycle_control_unit_if #(.CNT_W(TB_CNT_W)) bus ();

  multicycle_control_unit #(.MEM_TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit expValid = 1'b0;
  expT expCur = '0;
  logic [TB_CNT_W-1:0] expRet = '0;
  logic [TB_CNT_W-1:0] modelRet = '0;
  int cycInInstr = 0;
  int rstAtCyc = -1;
  bit aborted = 1'b0;

  int monDmemReq = 0, monRuWrCyc = 0, monPcWrCyc = 0, monTrapCyc = 0;
  logic [3:0] monAluOp = '0;
  logic       monAluB = 1'b0;
  logic [4:0] monBrOp = '0;

  logic [6:0] badOp [7] = '{OP_R,    OP_R,    OP_IARITH, OP_BRANCH, OP_LOAD, OP_STORE, OP_JALR};
  logic [2:0] badF3 [7] = '{3'b000,  3'b001,  3'b001,    3'b010,    3'b011,  3'b011,   3'b001};
  logic [6:0] badF7 [7] = '{7'h01,   7'h20,   7'h20,     7'h00,     7'h00,   7'h00,    7'h00};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Datapath controls from the single-cycle encoding table, independent of sequencing.
  function automatic expT fieldsOf(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    expT e;
    e = '0;
    case (op)
      OP_R:      e.aluOp = {f7[5], f3};
      OP_IARITH: begin e.aluB = 1'b1; e.aluOp = (f3 == 3'b101) ? {f7[5], f3} : {1'b0, f3}; end
      OP_LOAD:   begin e.aluB = 1'b1; e.ruSrc = 2'b01; e.dmCtrl = f3; end
      OP_STORE:  begin e.aluB = 1'b1; e.dmCtrl = f3; e.immSrc = 3'b001; end
      OP_BRANCH: begin e.immSrc = 3'b101; e.brOp = {2'b01, f3}; end
      OP_JAL:    begin e.immSrc = 3'b110; e.brOp = 5'b10000; e.ruSrc = 2'b10; end
      OP_JALR:   begin e.aluB = 1'b1; e.brOp = 5'b10000; e.ruSrc = 2'b10; end
      OP_LUI:    begin e.immSrc = 3'b010; e.ruSrc = 2'b11; end
      OP_AUIPC:  begin e.aluA = 1'b1; e.aluB = 1'b1; e.immSrc = 3'b010; end
      default:   e = '0;
    endcase
    return e;
  endfunction

  function automatic bit isLegal(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    case (op)
      OP_R:      return (f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5));
      OP_IARITH: begin
        if (f3 == 3'd1) return f7 == 7'h00;
        if (f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
        return 1'b1;
      end
      OP_BRANCH: return !(f3 == 3'd2 || f3 == 3'd3);
      OP_LOAD:   return !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      OP_STORE:  return f3 <= 3'd2;
      OP_JALR:   return f3 == 3'd0;
      OP_JAL, OP_LUI, OP_AUIPC: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic iRdy, input logic dRdy, input expT e);
    bus.OpCode    = op;
    bus.Funct3    = f3;
    bus.Funct7    = f7;
    bus.IMemReady = iRdy;
    bus.DMemReady = dRdy;
    if (cycInInstr == rstAtCyc) begin
      rst     = 1'b1;
      expCur  = '0;
      expRet  = '0;
      aborted = 1'b1;
    end else begin
      rst    = 1'b0;
      expCur = e;
      expRet = modelRet;
    end
    expValid = 1'b1;
    @(posedge clk);
    #1;
    if (rst) begin
      modelRet = '0;
      rst      = 1'b0;
    end else if (e.pcWr) begin
      modelRet = modelRet + 1'b1;
    end
    cycInInstr++;
  endtask

  task automatic applyReset(input int n);
    for (int i = 0; i < n; i++) begin
      rst      = 1'b1;
      expCur   = '0;
      expRet   = '0;
      expValid = 1'b1;
      @(posedge clk);
      #1;
      modelRet = '0;
    end
    rst = 1'b0;
  endtask

  task automatic holdTrap(input int n);
    expT e;
    e = '0;
    e.st = 3'd5;
    e.trap = 1'b1;
    rstAtCyc = -1;
    for (int i = 0; i < n; i++)
      applyStimulus(OP_STORE, 3'b010, 7'h00, 1'b1, 1'b1, e);
  endtask

  // One instruction at the phase level: fetch waits, decode, execute, memory waits, writeback.
  task automatic runInstr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input int iWait, input int dWait, input int rstAt);
    expT base, e;
    bit isLd, isSt, isBr, rdy;
    base = fieldsOf(op, f3, f7);
    isLd = (op == OP_LOAD);
    isSt = (op == OP_STORE);
    isBr = (op == OP_BRANCH);
    cycInInstr = 0;
    rstAtCyc   = rstAt;
    aborted    = 1'b0;
    monDmemReq = 0; monRuWrCyc = 0; monPcWrCyc = 0; monTrapCyc = 0;
    monAluOp = '0; monAluB = 1'b0; monBrOp = '0;
    for (int k = 0; k <= iWait; k++) begin
      rdy = (k == iWait);
      e = '0;
      e.imemReq = 1'b1;
      e.irWr = rdy;
      applyStimulus(7'h7F, 3'h7, 7'h7F, rdy, 1'b0, e);
      if (aborted) return;
      if (rdy) break;
      if (TB_TIMEOUT != 0 && k == TB_TIMEOUT) return;
    end
    e = base; e.st = 3'd1; e.brOp = '0;
    applyStimulus(op, f3, f7, 1'b1, 1'b1, e);
    if (aborted || !isLegal(op, f3, f7)) return;
    e = base; e.st = 3'd2; e.pcWr = isBr;
    applyStimulus(op, f3, f7, 1'b1, 1'b1, e);
    if (aborted || isBr) return;
    if (isLd || isSt) begin
      for (int k = 0; k <= dWait; k++) begin
        rdy = (k == dWait);
        e = base; e.st = 3'd3; e.brOp = '0;
        e.dmemReq = 1'b1; e.dmWr = isSt; e.pcWr = isSt && rdy;
        applyStimulus(op, f3, f7, 1'b1, rdy, e);
        if (aborted) return;
        if (rdy) break;
        if (TB_TIMEOUT != 0 && k == TB_TIMEOUT) return;
      end
      if (isSt) return;
    end
    e = base; e.st = 3'd4; e.brOp = '0; e.ruWr = 1'b1; e.pcWr = 1'b1;
    applyStimulus(op, f3, f7, 1'b1, 1'b1, e);
  endtask

  always @(negedge clk) begin
    if (expValid) begin
      checkOutput("State",       32'(bus.State),       32'(expCur.st));
      checkOutput("IMemReq",     32'(bus.IMemReq),     32'(expCur.imemReq));
      checkOutput("IRWr",        32'(bus.IRWr),        32'(expCur.irWr));
      checkOutput("DMemReq",     32'(bus.DMemReq),     32'(expCur.dmemReq));
      checkOutput("DMWr",        32'(bus.DMWr),        32'(expCur.dmWr));
      checkOutput("RUWr",        32'(bus.RUWr),        32'(expCur.ruWr));
      checkOutput("RUDataWrSrc", 32'(bus.RUDataWrSrc), 32'(expCur.ruSrc));
      checkOutput("ALUASrc",     32'(bus.ALUASrc),     32'(expCur.aluA));
      checkOutput("ALUBSrc",     32'(bus.ALUBSrc),     32'(expCur.aluB));
      checkOutput("ALUOp",       32'(bus.ALUOp),       32'(expCur.aluOp));
      checkOutput("DMCtrl",      32'(bus.DMCtrl),      32'(expCur.dmCtrl));
      checkOutput("ImmSrc",      32'(bus.ImmSrc),      32'(expCur.immSrc));
      checkOutput("BrOp",        32'(bus.BrOp),        32'(expCur.brOp));
      checkOutput("PCWr",        32'(bus.PCWr),        32'(expCur.pcWr));
      checkOutput("Trap",        32'(bus.Trap),        32'(expCur.trap));
`ifdef CTRL_PERF_CNT_EN
      checkOutput("InstRet",     32'(bus.InstRet),     32'(expRet));
`else
      checkOutput("InstRet",     32'(bus.InstRet),     32'd0);
`endif
      if (bus.DMemReq) monDmemReq++;
      if (bus.RUWr && monRuWrCyc == 0) monRuWrCyc = cycInInstr + 1;
      if (bus.PCWr && monPcWrCyc == 0) monPcWrCyc = cycInInstr + 1;
      if (bus.State == 3'd5 && monTrapCyc == 0) monTrapCyc = cycInInstr + 1;
      if (bus.State == 3'd2) begin
        monAluOp = bus.ALUOp;
        monAluB  = bus.ALUBSrc;
        monBrOp  = bus.BrOp;
      end
    end
  end

  initial begin
    bus.OpCode = '0; bus.Funct3 = '0; bus.Funct7 = '0;
    bus.IMemReady = 1'b0; bus.DMemReady = 1'b0;
    @(posedge clk);
    #1;
    applyReset(2);

    runInstr(OP_R, 3'b000, 7'h00, 0, 0, -1);
    checkOutput("addPcWrCycle", 32'(monPcWrCyc), 32'd4);
    checkOutput("addRuWrCycle", 32'(monRuWrCyc), 32'd4);
    checkOutput("addAluOp",     32'(monAluOp),   32'd0);

    runInstr(OP_IARITH, 3'b101, 7'h20, 0, 0, -1);
    checkOutput("sraiAluOp", 32'(monAluOp), 32'b1101);
    checkOutput("sraiAluB",  32'(monAluB),  32'd1);
    runInstr(OP_IARITH, 3'b101, 7'h00, 0, 0, -1);
    checkOutput("srliAluOp", 32'(monAluOp), 32'b0101);
    runInstr(OP_IARITH, 3'b001, 7'h00, 0, 0, -1);
    runInstr(OP_R, 3'b000, 7'h20, 1, 0, -1);
    runInstr(OP_R, 3'b101, 7'h20, 0, 0, -1);

    runInstr(OP_LOAD, 3'b010, 7'h00, 0, 3, -1);
    checkOutput("lwDmemReqCycles", 32'(monDmemReq), 32'd4);
    checkOutput("lwRuWrCycle",     32'(monRuWrCyc), 32'd8);
    checkOutput("lwPcWrCycle",     32'(monPcWrCyc), 32'd8);
    runInstr(OP_STORE, 3'b010, 7'h00, 0, 0, -1);
    checkOutput("swPcWrCycle", 32'(monPcWrCyc), 32'd4);
    runInstr(OP_LOAD, 3'b100, 7'h00, 2, 1, -1);
    runInstr(OP_STORE, 3'b000, 7'h00, 0, 2, -1);

    runInstr(OP_BRANCH, 3'b001, 7'h00, 0, 0, -1);
    checkOutput("bneBrOp",     32'(monBrOp),    32'b01001);
    checkOutput("bnePcWrCyc",  32'(monPcWrCyc), 32'd3);
    checkOutput("bneNoRuWr",   32'(monRuWrCyc), 32'd0);
    runInstr(OP_JAL,   3'b000, 7'h00, 0, 0, -1);
    runInstr(OP_JALR,  3'b000, 7'h00, 0, 0, -1);
    runInstr(OP_LUI,   3'b011, 7'h00, 0, 0, -1);
    runInstr(OP_AUIPC, 3'b110, 7'h00, 0, 0, -1);

    runInstr(OP_IARITH, 3'b000, 7'h00, TB_TIMEOUT, 0, -1);
    checkOutput("readyWinsPcWr", 32'(monPcWrCyc), 32'(TB_TIMEOUT + 4));
    checkOutput("readyWinsTrap", 32'(monTrapCyc), 32'd0);

    runInstr(7'b1111111, 3'b000, 7'h00, 0, 0, -1);
    holdTrap(5);
    checkOutput("illegalTrapCycle", 32'(monTrapCyc), 32'd3);
    applyReset(1);

    for (int i = 0; i < 7; i++) begin
      runInstr(badOp[i], badF3[i], badF7[i], 0, 0, -1);
      holdTrap(1);
      checkOutput("illegalFieldTrap", 32'(monTrapCyc), 32'd3);
      applyReset(1);
    end

    runInstr(OP_R, 3'b000, 7'h00, 1000, 0, -1);
    holdTrap(3);
    checkOutput("fetchTimeoutTrap", 32'(monTrapCyc), 32'd17);
    applyReset(1);

    runInstr(OP_LOAD, 3'b010, 7'h00, 0, 1000, -1);
    holdTrap(2);
    checkOutput("memTimeoutTrap", 32'(monTrapCyc), 32'd20);
    applyReset(1);

    runInstr(OP_STORE, 3'b010, 7'h00, 0, 2, 4);
    checkOutput("swResetDmemReq", 32'(monDmemReq), 32'd1);
    runInstr(OP_R, 3'b111, 7'h00, 0, 0, -1);

    applyReset(1);
    for (int i = 0; i < 17; i++)
      runInstr(OP_BRANCH, 3'b000, 7'h00, 0, 0, -1);
`ifdef CTRL_PERF_CNT_EN
    checkOutput("instRetWrap", 32'(bus.InstRet), 32'd1);
`else
    checkOutput("instRetTied", 32'(bus.InstRet), 32'd0);
`endif
    applyReset(1);
    checkOutput("instRetAfterReset", 32'(bus.InstRet), 32'd0);

    expValid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
